// File: rtl/round_ctrl_pkg.sv
// Shared codes for the round controller: game FSM states, result encodings,
// keypad codes and the round FSM state type.
package round_ctrl_pkg;

    localparam logic [2:0] ST_OFF  = 3'd0;
    localparam logic [2:0] ST_WLCM = 3'd1;
    localparam logic [2:0] ST_CH   = 3'd2;
    localparam logic [2:0] ST_GAME = 3'd3;
    localparam logic [2:0] ST_WL   = 3'd4;
    localparam logic [2:0] ST_PA   = 3'd5;

    localparam logic [1:0] WL_NONE = 2'b00;
    localparam logic [1:0] WL_LOST = 2'b01;
    localparam logic [1:0] WL_WON  = 2'b10;

    localparam logic [4:0] KEY_PWRB  = 5'd10;
    localparam logic [4:0] KEY_PAUSE = 5'd12;
    localparam logic [4:0] KEY_STB   = 5'd13;
    localparam logic [4:0] KEY_NO    = 5'd14;
    localparam logic [4:0] KEY_YES   = 5'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } round_state_t;

endpackage

// File: rtl/round_ctrl_tick_gen.sv
// One-second tick generator: counts 0..DIVISOR-1 while enabled and emits a
// registered one-cycle tick on the wrap. Holding en low freezes the count.
module tick_gen #(
    parameter int DIVISOR = 27000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + ONE;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Round controller: runs one timed round while the game FSM is in GAME,
// tracking seconds left, lives, pause and the win/loss result.
//
// state | meaning
// IDLE  | outside a round, outputs at their reload values
// RUN   | round in progress, divider counting, hits/goals honoured
// PAUSE | round frozen until the next PAUSE key press
// DONE  | result latched until the game FSM leaves GAME/WL
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int DIVISOR    = 27000000,
    parameter int ROUND_TIME = 60,
    parameter int LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] presente,
    input  logic       keypad_pressed,
    input  logic [4:0] key,
    input  logic       hit,
    input  logic       goal,
    output logic [1:0] W_or_L,
    output logic [6:0] time_left,
    output logic [1:0] lives,
    output logic       paused,
    output logic       tick
);

    localparam logic [6:0] T_INIT = 7'(ROUND_TIME);
    localparam logic [1:0] L_INIT = 2'(LIVES);

    round_state_t state, state_nx;
    logic [1:0]   wl_nx;
    logic [6:0]   time_nx, time_after;
    logic [1:0]   lives_nx, lives_after;
    logic         key_prev;
    logic         pause_edge, in_game, loss, reload;
    logic         div_en, div_clr, tick_raw;

    tick_gen #(.DIVISOR(DIVISOR)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick_raw)
    );

    assign tick = tick_raw;

    assign pause_edge  = keypad_pressed && !key_prev && (key == KEY_PAUSE);
    assign in_game     = (presente == ST_GAME);
    assign time_after  = (tick_raw && time_left != 7'd0) ? time_left - 7'd1 : time_left;
    assign lives_after = (hit && lives != 2'd0) ? lives - 2'd1 : lives;
    assign loss        = (time_after == 7'd0) || (lives_after == 2'd0);

    always_comb begin
        state_nx = state;
        wl_nx    = W_or_L;
        time_nx  = time_left;
        lives_nx = lives;
        div_en   = 1'b0;
        div_clr  = 1'b0;
        reload   = 1'b0;
        case (state)
            IDLE: begin
                reload = 1'b1;
                if (in_game) state_nx = RUN;
            end
            RUN: begin
                if (!in_game) begin
                    state_nx = IDLE;
                    reload   = 1'b1;
                end else begin
                    // Events of this cycle count even if a pause edge arrives with them.
                    time_nx  = time_after;
                    lives_nx = lives_after;
                    if (loss) begin
                        state_nx = DONE;
                        wl_nx    = WL_LOST;
                    end else if (goal) begin
                        state_nx = DONE;
                        wl_nx    = WL_WON;
                    end else if (pause_edge) begin
                        state_nx = PAUSE;
                    end else begin
                        div_en = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (!in_game) begin
                    state_nx = IDLE;
                    reload   = 1'b1;
                end else if (pause_edge) begin
                    state_nx = RUN;
                end
            end
            DONE: begin
                div_clr = 1'b1;
                if (!(in_game || presente == ST_WL)) begin
                    state_nx = IDLE;
                    reload   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                reload   = 1'b1;
            end
        endcase
        if (reload) begin
            wl_nx    = WL_NONE;
            time_nx  = T_INIT;
            lives_nx = L_INIT;
            div_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            W_or_L    <= WL_NONE;
            time_left <= T_INIT;
            lives     <= L_INIT;
            paused    <= 1'b0;
            key_prev  <= 1'b0;
        end else begin
            state     <= state_nx;
            W_or_L    <= wl_nx;
            time_left <= time_nx;
            lives     <= lives_nx;
            paused    <= (state_nx == PAUSE);
            key_prev  <= keypad_pressed;
        end
    end

endmodule
